// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 set-2 keyboard front end: key codes, prefixes,
// keyboard status bytes and the frame receiver state encoding.
package ps2_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    // Pause sends E1 plus seven more bytes that carry no key information
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int NUM_STATUS = 7;
    localparam logic [NUM_STATUS-1:0][7:0] STATUS_CODES = {
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    function automatic logic is_status(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (b == STATUS_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Keyboard pins plus the decoded key command stream toward the game controller.
interface ps2_key_decoder_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_valid;
    logic       break_valid;
    logic       key_extended;
    logic       frame_error;

    // Keyboard / consumer side
    modport master (
        output ps2_clk, ps2_data,
        input  keycode, key_valid, break_valid, key_extended, frame_error
    );

    // Decoder side
    modport slave (
        input  ps2_clk, ps2_data,
        output keycode, key_valid, break_valid, key_extended, frame_error
    );

endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 byte receiver: pin synchronizers, ps2_clk glitch filter, 11-bit frame
// FSM with odd-parity check and an inter-edge timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_s, data_s;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q, filt_dly_q;
    logic          strobe;

    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          timeout, good;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Lines idle high, so synchronizers and filter come out of reset at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
        end else begin
            filt_dly_q <= filt_q;
            if (clk_s == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_q     <= clk_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign strobe = filt_dly_q & ~filt_q;

    // Byte handoff and errors are decoded from the strobe cycle so the
    // top-level output registers land one cycle after the stop-bit strobe.
    assign timeout  = (state_q != ST_IDLE) && !strobe && (to_cnt_q == TO_LAST);
    assign good     = data_s && (^{shift_q, par_q});
    assign rx_byte  = shift_q;
    assign rx_valid = strobe && (state_q == ST_STOP) && good;
    assign rx_err   = timeout
                   || (strobe && (state_q == ST_IDLE) && data_s)
                   || (strobe && (state_q == ST_STOP) && !good);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            if (state_q == ST_IDLE || strobe) to_cnt_q <= '0;
            else                               to_cnt_q <= to_cnt_q + TW'(1);

            if (timeout) begin
                state_q <= ST_IDLE;
            end else if (strobe) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= data_s;
                        state_q <= ST_STOP;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: strips E0/F0 prefixes, swallows pause and status
// bytes, and emits single-cycle make/break pulses with a held keycode.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    ps2_key_decoder_if.slave  bus
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    logic [7:0] keycode_q, keycode_d;
    logic       key_ext_q, key_ext_d;
    logic       key_valid_q, key_valid_d;
    logic       break_valid_q, break_valid_d;
    logic       frame_error_q, frame_error_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;

    always_comb begin
        keycode_d     = keycode_q;
        key_ext_d     = key_ext_q;
        key_valid_d   = 1'b0;
        break_valid_d = 1'b0;
        frame_error_d = rx_err;
        ext_d         = ext_q;
        brk_d         = brk_q;
        skip_d        = skip_q;

        // A broken frame may have been part of a prefix sequence; forget it
        if (rx_err) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
        end else if (rx_valid) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte == PFX_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (rx_byte == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PFX_BRK) begin
                brk_d = 1'b1;
            end else if (is_status(rx_byte)) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else begin
                keycode_d     = rx_byte;
                key_ext_d     = ext_q;
                break_valid_d = brk_q;
                key_valid_d   = !brk_q;
                ext_d         = 1'b0;
                brk_d         = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keycode_q     <= '0;
            key_ext_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            break_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            skip_q        <= '0;
        end else begin
            keycode_q     <= keycode_d;
            key_ext_q     <= key_ext_d;
            key_valid_q   <= key_valid_d;
            break_valid_q <= break_valid_d;
            frame_error_q <= frame_error_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            skip_q        <= skip_d;
        end
    end

    assign bus.keycode      = keycode_q;
    assign bus.key_extended = key_ext_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.break_valid  = break_valid_q;
    assign bus.frame_error  = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: PS/2 frames in, event-level model of the decoder rules,
// per-cycle comparison of pulses and held keycode.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int HALF           = 40;   // PS/2 half period in clk cycles (sped up)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] kind;   // 0 make, 1 break, 2 frame error
        logic [7:0] code;
        logic       ext;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    longint     cyc      = 0;
    longint     last_fall = 0;
    longint     err_cyc  = 0;
    int         n_make = 0, n_brk = 0, n_err = 0;
    logic [7:0] hold_code = 8'h00;
    logic       hold_ext  = 1'b0;
    bit         m_ext = 0, m_brk = 0;
    int         m_skip = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decoder rules at byte level
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
            m_ext = 0; m_brk = 0;
        end else begin
            e.kind = m_brk ? 2'd1 : 2'd0;
            e.code = b;
            e.ext  = m_ext;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_err();
        ev_t e;
        e.kind = 2'd2; e.code = 8'h00; e.ext = 1'b0;
        exp_q.push_back(e);
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    // Compare process
    always @(posedge clk) begin
        ev_t e;
        logic [1:0] k;
        #1;
        cyc++;
        if (!rst_n) begin
            hold_code = 8'h00;
            hold_ext  = 1'b0;
            check("rst_keycode", bus.keycode, 8'h00);
            check("rst_pulses", {bus.key_valid, bus.break_valid, bus.frame_error}, 3'b000);
            check("rst_ext", bus.key_extended, 1'b0);
        end else if (bus.key_valid || bus.break_valid || bus.frame_error) begin
            check("make_and_break", bus.key_valid && bus.break_valid, 1'b0);
            k = bus.key_valid ? 2'd0 : (bus.break_valid ? 2'd1 : 2'd2);
            if (k == 2'd0) n_make++;
            else if (k == 2'd1) n_brk++;
            else begin n_err++; err_cyc = cyc; end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", k, 2'd3);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", k, e.kind);
                if (e.kind != 2'd2) begin
                    check("pulse_keycode", bus.keycode, e.code);
                    check("pulse_ext", bus.key_extended, e.ext);
                    hold_code = e.code;
                    hold_ext  = e.ext;
                end
            end
        end else begin
            check("hold_keycode", bus.keycode, hold_code);
            check("hold_ext", bus.key_extended, hold_ext);
        end
    end

    task automatic ps2_bit(input logic d, input bit glitch);
        bus.ps2_data = d;
        repeat (HALF/2) @(negedge clk);
        bus.ps2_clk = 1'b0;
        last_fall = cyc;
        if (glitch) begin
            repeat (10) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF - 13) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        bus.ps2_clk = 1'b1;
        if (glitch) begin
            repeat (15) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HALF/2 - 18) @(negedge clk);
        end else begin
            repeat (HALF/2) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        int mk, bk;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_keycode", bus.keycode, 8'h00);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Plain make
        send(8'h1C);
        check("A_keycode", bus.keycode, 8'h1C);
        check("A_ext", bus.key_extended, 1'b0);
        check("A_makes", n_make, 1);

        // Extended make, then extended break
        send(8'hE0); send(KEY_LEFT);
        check("left_keycode", bus.keycode, 8'h6B);
        check("left_ext", bus.key_extended, 1'b1);
        check("left_makes", n_make, 2);
        send(8'hE0); send(8'hF0); send(KEY_LEFT);
        check("left_brk", n_brk, 1);
        check("left_brk_makes", n_make, 2);
        check("left_brk_ext", bus.key_extended, 1'b1);

        // Parity errors; a corrupted frame after F0 must drop the break flag
        model_err(); send_frame(8'h29, 1'b1, 1'b0, 11);
        check("par_err", n_err, 1);
        check("par_no_make", n_make, 2);
        send(8'hF0);
        model_err(); send_frame(8'h29, 1'b1, 1'b0, 11);
        send(KEY_SPACE);
        check("space_make", n_make, 3);
        check("space_brk", n_brk, 1);
        check("space_keycode", bus.keycode, 8'h29);

        // Timeout after start + 5 data bits
        model_err(); send_frame(8'h75, 1'b0, 1'b0, 6);
        repeat (25000) @(negedge clk);
        check("timeout_err", n_err, 3);
        check("timeout_window", (err_cyc - last_fall >= TIMEOUT_CYCLES) &&
                                (err_cyc - last_fall <= TIMEOUT_CYCLES + 30), 1'b1);
        send(KEY_UP);
        check("up_keycode", bus.keycode, 8'h75);
        check("up_makes", n_make, 4);

        // Status bytes and pause sequence produce nothing
        mk = n_make; bk = n_brk;
        send(8'hAA); send(8'hFA);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_quiet", {n_make - mk, n_brk - bk}, 64'd0);
        send(KEY_DOWN);
        check("down_keycode", bus.keycode, 8'h72);
        check("down_makes", n_make, mk + 1);

        // Glitchy ps2_clk
        model_byte(KEY_RIGHT);
        send_frame(KEY_RIGHT, 1'b0, 1'b1, 11);
        check("glitch_keycode", bus.keycode, 8'h74);
        check("glitch_errs", n_err, 3);

        // Reset mid-frame
        send_frame(8'h1C, 1'b0, 1'b0, 4);
        rst_n = 1'b0;
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_skip = 0;
        repeat (3) @(negedge clk);
        check("midrst_keycode", bus.keycode, 8'h00);
        check("midrst_pulses", {bus.key_valid, bus.break_valid, bus.frame_error, bus.key_extended}, 4'b0000);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        mk = n_make;
        send(8'h1C);
        check("post_rst_make", n_make, mk + 1);
        check("post_rst_keycode", bus.keycode, 8'h1C);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
